fpga_cfg_loader: RTL and testbench
==================================

// Module: fpga_cfg_loader
// PURPOSE
//  Configuration-load stage directly upstream of the FPGA core. Accepts a byte-wide bitstream
//  over a valid/ready handshake, serialises it LSB-first, and drives the core's CLB scan chain,
//  then its connection scan chain. Generates the glitch-free scan clock and both scan enables.
//  Reports busy/done/error to the host.
// PARAMETERS
//  CLB_CHAIN_LEN   2048  bits in CLB scan chain; must be multiple of 8 (elaboration error otherwise)
//  CONN_CHAIN_LEN  4096  bits in connection chain (edge + array); must be multiple of 8
// PORTS
//  clk            in   1  system clock; all logic on posedge
//  rst_n          in   1  asynchronous, active-low reset
//  cfg_start      in   1  1-cycle pulse: begin a load (honoured only in IDLE/DONE/ERROR)
//  cfg_data       in   8  bitstream byte, bit0 shifted first
//  cfg_valid      in   1  cfg_data valid
//  cfg_ready      out  1  byte accepted when cfg_valid & cfg_ready
//  scan_clk       out  1  registered scan clock to core (clk/2 while shifting, idles low)
//  clb_scan_in    out  1  serial data, CLB chain
//  clb_scan_en    out  1  CLB chain shift enable
//  conn_scan_in   out  1  serial data, connection chain
//  conn_scan_en   out  1  connection chain shift enable
//  cfg_busy       out  1  high in CLB_SHIFT/CONN_SHIFT/CRC_CHK
//  cfg_done       out  1  high in DONE until next cfg_start
//  cfg_error      out  1  high in ERROR until next cfg_start (CRC build only)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; holding register empty; bit/byte counters 0.
//  FSM: IDLE -start-> CLB_SHIFT -last CLB bit-> CONN_SHIFT -last CONN bit-> DONE
//       (CRC build: CONN_SHIFT -> CRC_CHK -> DONE | ERROR). DONE/ERROR -start-> CLB_SHIFT.
//  cfg_start while busy: ignored. Counters cleared on every accepted start.
//  Buffering: 1-byte holding reg + 8-bit shift reg. cfg_ready = busy & holding reg empty;
//   holding reg refills while shift reg drains -> streaming at 1 byte / 16 clk without bubbles.
//  Bit timing, 2 clk per bit: phase0 drive data bit, scan_clk=0; phase1 scan_clk=1 (core captures
//   on scan_clk rising edge). Data stable through phase1 and following phase0 edge.
//  scan_en for a chain asserts one clk before its first phase0, deasserts one clk after its last
//   phase1; chains never enabled together. Unused chain's data held 0.
//  Starvation: if no byte is available at a bit boundary, stay in phase0: scan_clk low, scan_en
//   held, data held; resume on next accepted byte. No spurious scan_clk pulse.
//  Exactly CLB_CHAIN_LEN then CONN_CHAIN_LEN bits emitted; bit counter 16 bits, no wrap.
//  Bytes offered in IDLE/DONE/ERROR: cfg_ready=0, not consumed.
//  Async reset mid-load: immediate return to IDLE, scan_clk/scan_en drop to 0; core config is
//   then undefined and a full reload is required.
// CONFIGURATION
//  CFG_LOADER_CRC_EN defined: after the payload, two more bytes (CRC low byte first) are accepted
//   in CRC_CHK. CRC-16-CCITT (poly 0x1021, init 0xFFFF, bitwise, bits in shift order) over all
//   payload bits; match -> DONE, mismatch -> ERROR (cfg_error=1, cfg_done=0). No scan_clk in CRC_CHK.
//  Not defined: no CRC_CHK state, cfg_error tied 0, load ends at DONE after last payload bit.
// STRUCTURE
//  Package fpga_cfg_pkg: state encoding (IDLE, CLB_SHIFT, CONN_SHIFT, CRC_CHK, DONE, ERROR),
//   CRC polynomial/init constants, counter width localparam.
//  Sub-module cfg_byte_serializer: holding reg + shift reg + phase toggle; emits bit/bit_valid
//   and scan_clk. Top holds the FSM, counters and optional CRC.
// TESTING
//  1 Reset with cfg_valid=1 -> all outputs 0, cfg_ready=0, no scan_clk edge.
//  2 LEN=16/16, bytes 0xA5,0x3C,0xFF,0x01 back-to-back -> 16 CLB edges with bits 1,0,1,0,0,1,0,1,
//    0,0,1,1,1,1,0,0, then 16 CONN edges, cfg_done after 64+ clk, model chains match.
//  3 Valid dropped 40 clk mid-byte-2 -> scan_clk stays low 40 clk, final chain contents unchanged.
//  4 cfg_start pulsed during CONN_SHIFT -> ignored; load completes normally.
//  5 rst_n low at bit 9 -> outputs 0 in same cycle; new start reloads from bit 0 correctly.
//  6 CRC build: correct CRC bytes -> cfg_done=1; CRC low byte XOR 0x01 -> cfg_error=1, cfg_done=0.

Source files
------------

// File: rtl/fpga_cfg_loader_pkg.sv
// Shared types and constants for the FPGA configuration loader: FSM states,
// CRC-16-CCITT constants and the bit/byte counter width.
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CLB_SHIFT  = 3'd1,
        CONN_SHIFT = 3'd2,
        CRC_CHK    = 3'd3,
        DONE       = 3'd4,
        ERROR      = 3'd5
    } cfg_state_e;

    localparam int          CNT_W    = 16;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One bitwise CRC-16-CCITT step, bits fed in the order they are shifted out.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/fpga_cfg_loader_serializer.sv
// Byte-to-bit serializer: one holding byte plus an 8-bit shift register, LSB first,
// two clk per bit (phase0 drives data with scan_clk low, phase1 raises scan_clk).
module cfg_byte_serializer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       accept_en,
    input  logic       shift_en,
    input  logic       clk_en,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       mid_bit,
    output logic       emit,
    output logic       bit_out,
    output logic       scan_clk
);

    logic [7:0] hold_data;
    logic [7:0] shift_data;
    logic       hold_full;
    logic [3:0] shift_cnt;
    logic       phase;
    logic       accept;
    logic       take_shift;
    logic       take_hold;
    logic       take_in;
    logic       next_bit;

    assign ready   = accept_en & ~hold_full;
    assign accept  = valid & ready;
    assign mid_bit = phase;

    // A new bit may only start on a bit boundary; an empty pipeline takes the
    // incoming byte directly so a resumed stream costs no extra cycle.
    always_comb begin
        take_shift = shift_en & ~phase & (shift_cnt != 4'd0);
        take_hold  = shift_en & ~phase & (shift_cnt == 4'd0) & hold_full;
        take_in    = shift_en & ~phase & (shift_cnt == 4'd0) & ~hold_full & accept;
        emit       = take_shift | take_hold | take_in;
        next_bit   = data[0];
        if (take_shift) begin
            next_bit = shift_data[0];
        end else if (take_hold) begin
            next_bit = hold_data[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            shift_cnt <= 4'd0;
            phase     <= 1'b0;
            scan_clk  <= 1'b0;
            bit_out   <= 1'b0;
        end else if (clear) begin
            hold_full <= 1'b0;
            shift_cnt <= 4'd0;
            phase     <= 1'b0;
            scan_clk  <= 1'b0;
            bit_out   <= 1'b0;
        end else begin
            if (take_hold) begin
                hold_full <= 1'b0;
            end else if (accept && !take_in) begin
                hold_full <= 1'b1;
            end

            if (take_shift) begin
                shift_cnt <= shift_cnt - 4'd1;
            end else if (take_hold || take_in) begin
                shift_cnt <= 4'd7;
            end

            // Starved bit boundaries fall through to the last branch: clock low, data held.
            if (!shift_en) begin
                phase    <= 1'b0;
                scan_clk <= 1'b0;
                bit_out  <= 1'b0;
            end else if (phase) begin
                phase    <= 1'b0;
                scan_clk <= clk_en;
            end else if (emit) begin
                phase    <= 1'b1;
                scan_clk <= 1'b0;
                bit_out  <= next_bit;
            end else begin
                scan_clk <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !take_in) begin
            hold_data <= data;
        end
        if (take_shift) begin
            shift_data <= {1'b0, shift_data[7:1]};
        end else if (take_hold) begin
            shift_data <= {1'b0, hold_data[7:1]};
        end else if (take_in) begin
            shift_data <= {1'b0, data[7:1]};
        end
    end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Configuration loader: streams a byte bitstream into the CLB chain, then the connection
// chain. Optional trailing CRC-16 check is enabled by defining CFG_LOADER_CRC_EN.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CLB_CHAIN_LEN  = 2048,
    parameter int CONN_CHAIN_LEN = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_start,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic       scan_clk,
    output logic       clb_scan_in,
    output logic       clb_scan_en,
    output logic       conn_scan_in,
    output logic       conn_scan_en,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       cfg_error
);

`ifdef CFG_LOADER_CRC_EN
    localparam int CRC_BYTES = 2;
`else
    localparam int CRC_BYTES = 0;
`endif
    localparam int TOTAL_BYTES = (CLB_CHAIN_LEN + CONN_CHAIN_LEN) / 8 + CRC_BYTES;

    localparam logic [CNT_W-1:0] CLB_LEN_C   = CNT_W'(CLB_CHAIN_LEN);
    localparam logic [CNT_W-1:0] CONN_LEN_C  = CNT_W'(CONN_CHAIN_LEN);
    localparam logic [CNT_W-1:0] CRC_LEN_C   = CNT_W'(16);
    localparam logic [CNT_W-1:0] TOTAL_BYTES_C = CNT_W'(TOTAL_BYTES);

    if ((CLB_CHAIN_LEN % 8) != 0 || CLB_CHAIN_LEN <= 0 || CLB_CHAIN_LEN > 65535) begin : g_bad_clb_len
        $error("CLB_CHAIN_LEN must be a positive multiple of 8 below 65536");
    end
    if ((CONN_CHAIN_LEN % 8) != 0 || CONN_CHAIN_LEN <= 0 || CONN_CHAIN_LEN > 65535) begin : g_bad_conn_len
        $error("CONN_CHAIN_LEN must be a positive multiple of 8 below 65536");
    end

    cfg_state_e       state;
    cfg_state_e       state_d;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] cur_len;
    logic             start_ok;
    logic             busy;
    logic             chain_end;
    logic             shift_en;
    logic             accept_en;
    logic             clk_en;
    logic             mid_bit;
    logic             emit;
    logic             bit_out;
    logic             crc_ok;

    assign busy      = (state == CLB_SHIFT) || (state == CONN_SHIFT) || (state == CRC_CHK);
    assign start_ok  = cfg_start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    // A chain is finished once its last bit has completed phase1.
    assign chain_end = (bit_cnt == cur_len) && !mid_bit;
    assign shift_en  = busy && !chain_end;
    assign accept_en = busy && (byte_cnt != TOTAL_BYTES_C);
    assign clk_en    = (state != CRC_CHK);

    always_comb begin
        cur_len = '0;
        case (state)
            CLB_SHIFT:  cur_len = CLB_LEN_C;
            CONN_SHIFT: cur_len = CONN_LEN_C;
            CRC_CHK:    cur_len = CRC_LEN_C;
            default:    cur_len = '0;
        endcase
    end

    cfg_byte_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .accept_en (accept_en),
        .shift_en  (shift_en),
        .clk_en    (clk_en),
        .data      (cfg_data),
        .valid     (cfg_valid),
        .ready     (cfg_ready),
        .mid_bit   (mid_bit),
        .emit      (emit),
        .bit_out   (bit_out),
        .scan_clk  (scan_clk)
    );

`ifdef CFG_LOADER_CRC_EN
    logic [15:0] crc_acc;
    logic [15:0] crc_rx;

    // bit_out carries the freshly emitted bit while mid_bit is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_acc <= CRC_INIT;
            crc_rx  <= '0;
        end else if (start_ok) begin
            crc_acc <= CRC_INIT;
            crc_rx  <= '0;
        end else if (mid_bit) begin
            if (state == CRC_CHK) begin
                crc_rx <= {bit_out, crc_rx[15:1]};
            end else begin
                crc_acc <= crc16_step(crc_acc, bit_out);
            end
        end
    end

    assign crc_ok    = (crc_rx == crc_acc);
    assign cfg_error = (state == ERROR);
`else
    assign crc_ok    = 1'b1;
    assign cfg_error = 1'b0;
`endif

    always_comb begin
        state_d = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (cfg_start) begin
                    state_d = CLB_SHIFT;
                end
            end
            CLB_SHIFT: begin
                if (chain_end) begin
                    state_d = CONN_SHIFT;
                end
            end
            CONN_SHIFT: begin
                if (chain_end) begin
`ifdef CFG_LOADER_CRC_EN
                    state_d = CRC_CHK;
`else
                    state_d = DONE;
`endif
                end
            end
            CRC_CHK: begin
                if (chain_end) begin
                    state_d = crc_ok ? DONE : ERROR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            clb_scan_en  <= 1'b0;
            conn_scan_en <= 1'b0;
        end else begin
            state        <= state_d;
            clb_scan_en  <= (state_d == CLB_SHIFT);
            conn_scan_en <= (state_d == CONN_SHIFT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
        end else if (start_ok) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
        end else begin
            if (busy && chain_end) begin
                bit_cnt <= '0;
            end else if (emit) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (cfg_valid && cfg_ready) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

    assign clb_scan_in  = bit_out & clb_scan_en;
    assign conn_scan_in = bit_out & conn_scan_en;
    assign cfg_busy     = busy;
    assign cfg_done     = (state == DONE);

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard bench for fpga_cfg_loader with 16-bit chains: the driver queues the
// expected chain/bit per accepted byte, the monitor pops one entry per scan_clk rise.
module tb_fpga_cfg_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_start;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       scan_clk;
    logic       clb_scan_in;
    logic       clb_scan_en;
    logic       conn_scan_in;
    logic       conn_scan_en;
    logic       cfg_busy;
    logic       cfg_done;
    logic       cfg_error;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    int cyc_now = 0;
    logic prev_sclk = 1'b0;
    logic [15:0] clb_model = '0;
    logic [15:0] conn_model = '0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    fpga_cfg_loader #(
        .CLB_CHAIN_LEN  (16),
        .CONN_CHAIN_LEN (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_start    (cfg_start),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .scan_clk     (scan_clk),
        .clb_scan_in  (clb_scan_in),
        .clb_scan_en  (clb_scan_en),
        .conn_scan_in (conn_scan_in),
        .conn_scan_en (conn_scan_en),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done),
        .cfg_error    (cfg_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every scan_clk rising edge must match the next queued bit on the right chain.
    always @(negedge clk) begin
        cyc_now++;
        if (!rst_n) begin
            prev_sclk = 1'b0;
        end else begin
            if (scan_clk && !prev_sclk) begin
                edge_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_edge actual=edge%0d required=none", edge_cnt);
                end else begin
                    logic [1:0] e;
                    logic [3:0] exp_v;
                    e = exp_q.pop_front();
                    exp_v = e[1] ? {2'b01, 1'b0, e[0]} : {2'b10, e[0], 1'b0};
                    check("edge_bit", {clb_scan_en, conn_scan_en, clb_scan_in, conn_scan_in}, exp_v);
                end
                if (clb_scan_en)  clb_model  = {clb_model[14:0], clb_scan_in};
                if (conn_scan_en) conn_model = {conn_model[14:0], conn_scan_in};
            end
            prev_sclk = scan_clk;
        end
    end

    task automatic do_start();
        clb_model  = '0;
        conn_model = '0;
        edge_cnt   = 0;
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic to_conn, input logic push_exp);
        int n;
        n = 0;
        cfg_data  = b;
        cfg_valid = 1'b1;
        while (!cfg_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) begin
            check("byte_accept_timeout", 32'd0, 32'd1);
        end else if (push_exp) begin
            for (int i = 0; i < 8; i++) exp_q.push_back({to_conn, b[i]});
        end
        @(negedge clk);
    endtask

    task automatic wait_end(input string name, input logic [1:0] exp_de);
        int n;
        n = 0;
        while (!(cfg_done || cfg_error) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, {cfg_done, cfg_error}, exp_de);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_idle_outputs"}, {scan_clk, clb_scan_en, conn_scan_en, cfg_busy}, 4'b0000);
    endtask

    task automatic check_chains(input string name, input logic [15:0] exp_clb, input logic [15:0] exp_conn);
        check({name, "_clb_chain"}, clb_model, exp_clb);
        check({name, "_conn_chain"}, conn_model, exp_conn);
    endtask

    function automatic logic [15:0] crc_of(input logic [31:0] w);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            fb = c[15] ^ w[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    initial begin
        int t0;
        int n;
        logic bad;
        logic [15:0] crc;

        // Reset with a byte on offer.
        rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b1; cfg_data = 8'hFF;
        repeat (3) @(negedge clk);
        check("reset_outputs", {scan_clk, clb_scan_in, clb_scan_en, conn_scan_in, conn_scan_en,
                                cfg_busy, cfg_done, cfg_error, cfg_ready}, 9'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_byte_not_taken", {cfg_ready, cfg_busy, cfg_done}, 3'b000);
        check("idle_no_edges", edge_cnt, 0);
        cfg_valid = 1'b0;

        // Back-to-back load.
        t0 = cyc_now;
        do_start();
        send_byte(8'hA5, 1'b0, 1'b1);
        send_byte(8'h3C, 1'b0, 1'b1);
        send_byte(8'hFF, 1'b1, 1'b1);
        send_byte(8'h01, 1'b1, 1'b1);
        cfg_valid = 1'b0;
        wait_end("load1_done", 2'b10);
        check("load1_latency_ge64", (cyc_now - t0) >= 64, 1);
        check("load1_edges", edge_cnt, 32);
        check_chains("load1", 16'hA53C, 16'hFF80);
        cfg_valid = 1'b1; cfg_data = 8'h55;
        repeat (5) @(negedge clk);
        check("done_byte_not_taken", {cfg_ready, cfg_done}, 2'b01);
        check("done_no_edges", edge_cnt, 32);
        cfg_valid = 1'b0;

        // Starvation: host stalls after the first byte.
        do_start();
        send_byte(8'hA5, 1'b0, 1'b1);
        cfg_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("starve_edges_before", edge_cnt, 8);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (scan_clk || !clb_scan_en || !clb_scan_in || conn_scan_en) bad = 1'b1;
        end
        check("starve_no_edges", edge_cnt, 8);
        check("starve_held", bad, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b1);
        send_byte(8'hFF, 1'b1, 1'b1);
        send_byte(8'h01, 1'b1, 1'b1);
        cfg_valid = 1'b0;
        wait_end("starve_done", 2'b10);
        check_chains("starve", 16'hA53C, 16'hFF80);

        // Start pulse during CONN_SHIFT is ignored.
        do_start();
        send_byte(8'h12, 1'b0, 1'b1);
        send_byte(8'h34, 1'b0, 1'b1);
        send_byte(8'h56, 1'b1, 1'b1);
        cfg_valid = 1'b0;
        n = 0;
        while (!conn_scan_en && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("conn_reached", conn_scan_en, 1'b1);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("start_ignored", {cfg_busy, clb_scan_en, conn_scan_en}, 3'b101);
        send_byte(8'h78, 1'b1, 1'b1);
        cfg_valid = 1'b0;
        wait_end("ignstart_done", 2'b10);
        check_chains("ignstart", 16'h482C, 16'h6A1E);

        // Asynchronous reset at bit 9, then full reload.
        do_start();
        send_byte(8'hA5, 1'b0, 1'b1);
        send_byte(8'h3C, 1'b0, 1'b1);
        cfg_valid = 1'b0;
        n = 0;
        while (edge_cnt < 9 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_bit9", edge_cnt, 9);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midload_reset_outputs", {scan_clk, clb_scan_in, clb_scan_en, conn_scan_in, conn_scan_en,
                                        cfg_busy, cfg_done, cfg_error, cfg_ready}, 9'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        send_byte(8'h12, 1'b0, 1'b1);
        send_byte(8'h34, 1'b0, 1'b1);
        send_byte(8'h56, 1'b1, 1'b1);
        send_byte(8'h78, 1'b1, 1'b1);
        cfg_valid = 1'b0;
        wait_end("reload_done", 2'b10);
        check_chains("reload", 16'h482C, 16'h6A1E);

`ifdef CFG_LOADER_CRC_EN
        crc = crc_of(32'h01FF3CA5);
        do_start();
        send_byte(8'hA5, 1'b0, 1'b1);
        send_byte(8'h3C, 1'b0, 1'b1);
        send_byte(8'hFF, 1'b1, 1'b1);
        send_byte(8'h01, 1'b1, 1'b1);
        send_byte(crc[7:0], 1'b0, 1'b0);
        send_byte(crc[15:8], 1'b0, 1'b0);
        cfg_valid = 1'b0;
        wait_end("crc_good", 2'b10);
        do_start();
        send_byte(8'hA5, 1'b0, 1'b1);
        send_byte(8'h3C, 1'b0, 1'b1);
        send_byte(8'hFF, 1'b1, 1'b1);
        send_byte(8'h01, 1'b1, 1'b1);
        send_byte(crc[7:0] ^ 8'h01, 1'b0, 1'b0);
        send_byte(crc[15:8], 1'b0, 1'b0);
        cfg_valid = 1'b0;
        wait_end("crc_bad", 2'b01);
`else
        crc = crc_of(32'h0);
        check("no_crc_error_low", cfg_error, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
